// File: rtl/adt7420_poll_ctrl.sv
// -----------------------------------------------------------------------------
// adt7420_poll_ctrl
//
// Purpose:
//   Drives the request side of an i2c_master to look after one ADT7420
//   temperature sensor. After reset it writes the configuration register
//   (sub-address 0x03). It then reads the 16-bit temperature register
//   (sub-address 0x00) again and again, with a fixed gap between reads.
//   Each good sample goes out on temp with a one-cycle temp_valid pulse.
//   Failed transactions are retried. When MAX_RETRY failures happen in a
//   row, the sticky err flag is set and the controller parks until i_clear.
//
// Optional feature (macro ADT_OVERTEMP_EN):
//   When defined, this adds the signed threshold input i_thresh and the
//   over_temp output. over_temp is updated together with temp.
//
// Ports:
//   i_clk         in   1   system clock
//   reset_n       in   1   synchronous active-low reset
//   i_en          in   1   1 = run; 0 = finish current transaction, then idle
//   i_clear       in   1   pulse: clear err/retry_cnt, restart from config
//   o_addr_w_rw   out  8   {DEV_ADDR, r/w} to i2c_master
//   o_sub_addr    out  16  register sub-address to i2c_master
//   o_sub_len     out  1   sub-address length select (always 0: one byte)
//   o_byte_len    out  24  number of data bytes in the transaction
//   o_data_write  out  8   write data (always CFG_VALUE)
//   o_req_trans   out  1   one-cycle request pulse
//   i_data_out    in   8   read data byte from i2c_master
//   i_valid_out   in   1   i_data_out qualifier
//   i_busy        in   1   i2c_master transaction in progress
//   i_nack        in   1   slave did not acknowledge
//   temp          out  16  last good sample {MSB, LSB}
//   temp_valid    out  1   one-cycle pulse when temp updates
//   err           out  1   sticky: MAX_RETRY consecutive failures
//   retry_cnt     out  4   consecutive failure count
//   i_thresh      in   16  (ADT_OVERTEMP_EN) signed over-temperature threshold
//   over_temp     out  1   (ADT_OVERTEMP_EN) last sample > i_thresh
// -----------------------------------------------------------------------------
module adt7420_poll_ctrl #(
  parameter logic [6:0]  DEV_ADDR    = 7'h4B,
  parameter logic [7:0]  CFG_VALUE   = 8'h80,
  parameter int unsigned POLL_PERIOD = 25000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_clear,
  output logic [7:0]  o_addr_w_rw,
  output logic [15:0] o_sub_addr,
  output logic        o_sub_len,
  output logic [23:0] o_byte_len,
  output logic [7:0]  o_data_write,
  output logic        o_req_trans,
  input  logic [7:0]  i_data_out,
  input  logic        i_valid_out,
  input  logic        i_busy,
  input  logic        i_nack,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        err,
  output logic [3:0]  retry_cnt
`ifdef ADT_OVERTEMP_EN
  ,
  input  logic signed [15:0] i_thresh,
  output logic               over_temp
`endif
);

  // The poll counter only has to hold POLL_PERIOD-1.
  localparam int unsigned          PW          = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0]        POLL_RELOAD = PW'(POLL_PERIOD - 1);
  localparam logic [3:0]           RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_EVAL,
    S_POLL,
    S_ERROR
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_op_read;     // 0 = config write, 1 = temperature read
  logic            r_cfg_done;
  logic            r_nack_seen;
  logic            r_timeout;     // busy never rose after the request
  logic            r_discard;     // i_clear arrived while a transaction was in flight
  logic [1:0]      r_byte_idx;    // read bytes captured so far (saturates at 2)
  logic [3:0]      r_wb_cnt;
  logic [PW-1:0]   r_poll_cnt;
  logic [7:0]      r_shadow_msb;
  logic [7:0]      r_shadow_lsb;

  logic [7:0]      r_addr_w_rw;
  logic [15:0]     r_sub_addr;
  logic [23:0]     r_byte_len;
  logic            r_req_trans;
  logic [15:0]     r_temp;
  logic            r_temp_valid;
  logic            r_err;
  logic [3:0]      r_retry_cnt;

  logic            w_success;
  logic            w_discard;
  logic            w_hit_max;
  logic [3:0]      w_retry_inc;
  logic [15:0]     w_shadow;

  assign w_shadow    = {r_shadow_msb, r_shadow_lsb};
  assign w_success   = !r_nack_seen && !r_timeout && (!r_op_read || (r_byte_idx == 2'd2));
  // A clear during EVAL takes priority over anything EVAL would record.
  assign w_discard   = r_discard || i_clear;
  assign w_retry_inc = r_retry_cnt + 4'd1;
  assign w_hit_max   = (w_retry_inc == RETRY_LIMIT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A clear in IDLE holds for a cycle so the next operation is the config write.
        if (i_en && !i_busy && !i_clear) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_wb_cnt == 4'd15) begin
          w_state_next = S_EVAL;
        end
      end
      S_WAIT_DONE: begin
        if (!i_busy) begin
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_discard) begin
          w_state_next = S_IDLE;
        end else if (!w_success && w_hit_max) begin
          w_state_next = S_ERROR;
        end else if (!i_en) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_POLL;
        end
      end
      S_POLL: begin
        if (i_clear || !i_en || (r_poll_cnt == '0)) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERROR: begin
        if (i_clear) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_op_read    <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_nack_seen  <= 1'b0;
      r_timeout    <= 1'b0;
      r_discard    <= 1'b0;
      r_byte_idx   <= 2'd0;
      r_wb_cnt     <= 4'd0;
      r_poll_cnt   <= '0;
      r_shadow_msb <= 8'h00;
      r_shadow_lsb <= 8'h00;
      r_addr_w_rw  <= {DEV_ADDR, 1'b0};
      r_sub_addr   <= 16'h0000;
      r_byte_len   <= 24'd0;
      r_req_trans  <= 1'b0;
      r_temp       <= 16'h0000;
      r_temp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_retry_cnt  <= 4'd0;
`ifdef ADT_OVERTEMP_EN
      over_temp    <= 1'b0;
`endif
    end else begin
      r_req_trans  <= 1'b0;
      r_temp_valid <= 1'b0;

      if (i_clear) begin
        r_err       <= 1'b0;
        r_retry_cnt <= 4'd0;
        r_cfg_done  <= 1'b0;
      end

      // Result of an in-flight transaction is thrown away after a clear.
      if (i_clear && (r_state inside {S_REQ, S_WAIT_BUSY, S_WAIT_DONE})) begin
        r_discard <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_REQ) begin
            // Operands are loaded here and held until the next request.
            r_op_read   <= r_cfg_done;
            r_req_trans <= 1'b1;
            r_discard   <= 1'b0;
            if (r_cfg_done) begin
              r_addr_w_rw <= {DEV_ADDR, 1'b1};
              r_sub_addr  <= 16'h0000;
              r_byte_len  <= 24'd2;
            end else begin
              r_addr_w_rw <= {DEV_ADDR, 1'b0};
              r_sub_addr  <= 16'h0003;
              r_byte_len  <= 24'd1;
            end
          end
        end
        S_REQ: begin
          r_nack_seen <= 1'b0;
          r_timeout   <= 1'b0;
          r_byte_idx  <= 2'd0;
          r_wb_cnt    <= 4'd0;
        end
        S_WAIT_BUSY: begin
          r_wb_cnt <= r_wb_cnt + 4'd1;
          if (!i_busy && (r_wb_cnt == 4'd15)) begin
            r_timeout <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i_nack) begin
            r_nack_seen <= 1'b1;
          end
          // Only the first two data bytes count; later pulses are ignored.
          if (r_op_read && i_valid_out) begin
            if (r_byte_idx == 2'd0) begin
              r_shadow_msb <= i_data_out;
              r_byte_idx   <= 2'd1;
            end else if (r_byte_idx == 2'd1) begin
              r_shadow_lsb <= i_data_out;
              r_byte_idx   <= 2'd2;
            end
          end
        end
        S_EVAL: begin
          if (!w_discard) begin
            r_poll_cnt <= POLL_RELOAD;
            if (w_success) begin
              r_retry_cnt <= 4'd0;
              if (!r_op_read) begin
                r_cfg_done <= 1'b1;
                r_poll_cnt <= '0;   // first read follows the config write at once
              end else begin
                r_temp       <= w_shadow;
                r_temp_valid <= 1'b1;
`ifdef ADT_OVERTEMP_EN
                over_temp    <= ($signed(w_shadow) > i_thresh);
`endif
              end
            end else begin
              r_retry_cnt <= w_retry_inc;
              if (w_hit_max) begin
                r_err <= 1'b1;
              end
            end
          end
        end
        S_POLL: begin
          if (r_poll_cnt != '0) begin
            r_poll_cnt <= r_poll_cnt - PW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_addr_w_rw  = r_addr_w_rw;
  assign o_sub_addr   = r_sub_addr;
  assign o_sub_len    = 1'b0;
  assign o_byte_len   = r_byte_len;
  assign o_data_write = CFG_VALUE;
  assign o_req_trans  = r_req_trans;
  assign temp         = r_temp;
  assign temp_valid   = r_temp_valid;
  assign err          = r_err;
  assign retry_cnt    = r_retry_cnt;

endmodule

// File: tb/tb_adt7420_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adt7420_poll_ctrl
//
// Testbench for adt7420_poll_ctrl. An i2c_master/slave responder executes a
// queue of per-transaction plans (ACK, NACK, no busy, short or long read).
// A transaction-level model computes the expected retry_cnt, err, temp and
// temp_valid count from the outcome of each plan.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adt7420_poll_ctrl;

  localparam int P  = 50;
  localparam int MR = 3;
  localparam logic [7:0] ADDR_W = {7'h4B, 1'b0};
  localparam logic [7:0] ADDR_R = {7'h4B, 1'b1};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_clear = 1'b0;
  logic [7:0]  o_addr_w_rw;
  logic [15:0] o_sub_addr;
  logic        o_sub_len;
  logic [23:0] o_byte_len;
  logic [7:0]  o_data_write;
  logic        o_req_trans;
  logic [7:0]  i_data_out = 8'h00;
  logic        i_valid_out = 1'b0;
  logic        i_busy = 1'b0;
  logic        i_nack = 1'b0;
  logic [15:0] temp;
  logic        temp_valid;
  logic        err;
  logic [3:0]  retry_cnt;
`ifdef ADT_OVERTEMP_EN
  logic signed [15:0] i_thresh = 16'sh0C00;
  logic               over_temp;
`endif

  adt7420_poll_ctrl #(
    .DEV_ADDR   (7'h4B),
    .CFG_VALUE  (8'h80),
    .POLL_PERIOD(P),
    .MAX_RETRY  (MR)
  ) dut (
    .i_clk       (clk),
    .reset_n     (reset_n),
    .i_en        (i_en),
    .i_clear     (i_clear),
    .o_addr_w_rw (o_addr_w_rw),
    .o_sub_addr  (o_sub_addr),
    .o_sub_len   (o_sub_len),
    .o_byte_len  (o_byte_len),
    .o_data_write(o_data_write),
    .o_req_trans (o_req_trans),
    .i_data_out  (i_data_out),
    .i_valid_out (i_valid_out),
    .i_busy      (i_busy),
    .i_nack      (i_nack),
    .temp        (temp),
    .temp_valid  (temp_valid),
    .err         (err),
    .retry_cnt   (retry_cnt)
`ifdef ADT_OVERTEMP_EN
    ,
    .i_thresh    (i_thresh),
    .over_temp   (over_temp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         nack;
    bit         nobusy;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
  } plan_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] sub;
    logic [23:0] len;
  } req_t;

  plan_t plan_q[$];
  plan_t phase_q[$];
  req_t  req_q[$];
  int    req_total = 0;
  int    txn_done = 0;
  int    underflow = 0;
  int    req_cyc [0:255];
  int    fall_cyc[0:255];
  int    cycle = 0;

  int    n_checks = 0;
  int    n_fail = 0;
  int    t_idx = 0;

  // transaction-level model state
  bit          m_cfg_done = 0;
  int          m_retry = 0;
  bit          m_err = 0;
  logic [15:0] m_temp = 16'h0000;
  int          m_tv = 0;
  bit          m_over = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // temp_valid monitor: pulse count and detection of pulses wider than 1 cycle
  int tv_count = 0;
  bit tv_prev = 0;
  bit tv_long = 0;
  always @(negedge clk) begin
    if (temp_valid === 1'b1) begin
      tv_count <= tv_count + 1;
      if (tv_prev) tv_long <= 1'b1;
    end
    tv_prev <= (temp_valid === 1'b1);
  end

  // i2c_master + slave responder
  initial begin : responder
    plan_t p;
    int    n;
    forever begin
      @(negedge clk);
      if (o_req_trans === 1'b1 && reset_n === 1'b1) begin
        n = req_total;
        req_q.push_back('{o_addr_w_rw, o_sub_addr, o_byte_len});
        if (n < 256) req_cyc[n] = cycle;
        req_total++;
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin
          underflow++;
          p = '{1'b0, 1'b0, 2, 8'h00, 8'h00};
        end
        if (p.nobusy) begin
          txn_done++;
        end else begin
          @(negedge clk); i_busy = 1'b1;
          repeat (2) @(negedge clk);
          if (p.nack) begin
            i_nack = 1'b1;
            @(negedge clk); i_nack = 1'b0;
          end else begin
            for (int b = 0; b < p.nbytes; b++) begin
              i_data_out  = (b == 0) ? p.b0 : (b == 1) ? p.b1 : ~p.b0;
              i_valid_out = 1'b1;
              @(negedge clk); i_valid_out = 1'b0;
              @(negedge clk);
            end
          end
          @(negedge clk); i_busy = 1'b0;
          if (n < 256) fall_cyc[n] = cycle;
          txn_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic plan_t mk(input bit nack, input bit nobusy, input int nb,
                               input logic [7:0] b0, input logic [7:0] b1);
    plan_t p;
    p.nack = nack; p.nobusy = nobusy; p.nbytes = nb; p.b0 = b0; p.b1 = b1;
    return p;
  endfunction

  // Wait for the next planned transaction, update the model, compare.
  task automatic expect_txn(input plan_t p, input string tag);
    int   guard;
    bit   is_cfg;
    bit   ok;
    req_t r;
    guard = 0;
    while (txn_done <= t_idx && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " done"}, 32'(txn_done > t_idx), 32'd1);
    repeat (p.nobusy ? 21 : 3) @(negedge clk);

    is_cfg = !m_cfg_done;
    check({tag, " req_seen"}, 32'(req_q.size() > 0), 32'd1);
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      check({tag, " addr"}, 32'(r.addr), is_cfg ? 32'(ADDR_W) : 32'(ADDR_R));
      check({tag, " sub"},  32'(r.sub),  is_cfg ? 32'h3 : 32'h0);
      check({tag, " len"},  32'(r.len),  is_cfg ? 32'd1 : 32'd2);
    end

    ok = !p.nack && !p.nobusy && (is_cfg || p.nbytes >= 2);
    if (ok) begin
      m_retry = 0;
      if (is_cfg) m_cfg_done = 1;
      else begin
        m_temp = {p.b0, p.b1};
        m_tv++;
`ifdef ADT_OVERTEMP_EN
        m_over = ($signed(m_temp) > i_thresh);
`endif
      end
    end else begin
      m_retry++;
      if (m_retry == MR) m_err = 1;
    end

    check({tag, " retry_cnt"}, 32'(retry_cnt), 32'(m_retry));
    check({tag, " err"},       32'(err),       32'(m_err));
    check({tag, " temp"},      32'(temp),      32'(m_temp));
    check({tag, " tv_count"},  32'(tv_count),  32'(m_tv));
`ifdef ADT_OVERTEMP_EN
    check({tag, " over_temp"}, 32'(over_temp), 32'(m_over));
`endif
    $display("txn %0d %s cfg=%0d ok=%0d temp=%h retry=%0d err=%0d",
             t_idx, tag, is_cfg, ok, temp, retry_cnt, err);
    t_idx++;
  endtask

  task automatic run_phase(input string tag);
    plan_t cur[$];
    cur = phase_q;
    phase_q.delete();
    foreach (cur[k]) plan_q.push_back(cur[k]);
    foreach (cur[k]) expect_txn(cur[k], $sformatf("%s[%0d]", tag, k));
  endtask

  initial begin : stim
    logic [31:0] rnd;
    int          sel;
    int          fr;
    int          guard;
    int          gap;
    int          reqs_at_err;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst temp",       32'(temp),         32'h0);
    check("rst temp_valid", 32'(temp_valid),   32'h0);
    check("rst err",        32'(err),          32'h0);
    check("rst retry_cnt",  32'(retry_cnt),    32'h0);
    check("rst req_trans",  32'(o_req_trans),  32'h0);
    check("rst addr",       32'(o_addr_w_rw),  32'(ADDR_W));
    check("rst sub",        32'(o_sub_addr),   32'h0);
    check("rst len",        32'(o_byte_len),   32'h0);
    check("rst sub_len",    32'(o_sub_len),    32'h0);
    check("rst data_write", 32'(o_data_write), 32'h80);

    // ---------------- config, fixed read, random reads ----------------
    phase_q.push_back(mk(0, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(0, 0, 2, 8'h0C, 8'h80));
    rnd = $urandom;
    phase_q.push_back(mk(0, 0, 2, rnd[7:0], rnd[15:8]));
    rnd = $urandom;
    phase_q.push_back(mk(0, 0, 3, rnd[7:0], rnd[15:8]));   // extra valid pulse
    reset_n = 1'b1;
    i_en    = 1'b1;
    run_phase("basic");
    check("temp_valid width", 32'(tv_long), 32'd0);
    gap = req_cyc[2] - fall_cyc[1];
    check("poll gap in range", 32'(gap >= P && gap <= P + 6), 32'd1);

    // ---------------- two NACKs then ACK ----------------
    rnd = $urandom;
    phase_q.push_back(mk(1, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(1, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(0, 0, 2, rnd[7:0], rnd[15:8]));
    run_phase("nack2");

    // ---------------- random outcomes ----------------
    fr = 0;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 9);
      rnd = $urandom;
      if (fr == MR - 1 || i == 7) sel = 9;
      case (sel)
        0, 1:    phase_q.push_back(mk(1, 0, 0, rnd[7:0], rnd[15:8]));
        2:       phase_q.push_back(mk(0, 0, 1, rnd[7:0], rnd[15:8]));
        3:       phase_q.push_back(mk(0, 0, 3, rnd[7:0], rnd[15:8]));
        default: phase_q.push_back(mk(0, 0, 2, rnd[7:0], rnd[15:8]));
      endcase
      fr = (sel <= 2) ? fr + 1 : 0;
    end
    run_phase("rand");

    // ---------------- three NACKs -> error, then clear ----------------
    phase_q.push_back(mk(1, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(1, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(1, 0, 0, 8'h00, 8'h00));
    run_phase("nack3");
    reqs_at_err = req_total;
    repeat (1000) @(negedge clk);
    check("no req in error", 32'(req_total), 32'(reqs_at_err));
    check("err held",        32'(err),       32'd1);

    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    m_err = 0; m_retry = 0; m_cfg_done = 0;
    check("clear err",   32'(err),       32'd0);
    check("clear retry", 32'(retry_cnt), 32'd0);
    rnd = $urandom;
    phase_q.push_back(mk(0, 0, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(0, 0, 2, rnd[7:0], rnd[15:8]));
    run_phase("clear");

    // ---------------- busy never rises ----------------
    rnd = $urandom;
    phase_q.push_back(mk(0, 1, 0, 8'h00, 8'h00));
    phase_q.push_back(mk(0, 0, 2, rnd[7:0], rnd[15:8]));
    run_phase("nobusy");
    check("plan underflow", 32'(underflow), 32'd0);

    // ---------------- reset during WAIT_DONE ----------------
    plan_q.push_back(mk(0, 0, 2, 8'h55, 8'hAA));
    guard = 0;
    while (i_busy !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("busy seen before reset", 32'(i_busy), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    i_en    = 1'b0;
    @(negedge clk);
    check("mid rst temp",       32'(temp),        32'h0);
    check("mid rst temp_valid", 32'(temp_valid),  32'h0);
    check("mid rst err",        32'(err),         32'h0);
    check("mid rst retry_cnt",  32'(retry_cnt),   32'h0);
    check("mid rst req_trans",  32'(o_req_trans), 32'h0);
    check("mid rst addr",       32'(o_addr_w_rw), 32'(ADDR_W));
    check("mid rst sub",        32'(o_sub_addr),  32'h0);
    check("mid rst len",        32'(o_byte_len),  32'h0);
`ifdef ADT_OVERTEMP_EN
    check("mid rst over_temp",  32'(over_temp),   32'h0);
`endif
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
